// File: rtl/cpu_pkg.sv
// Shared encodings for the CPU load path: access sizes and memory data register states.
package cpu_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } mdr_state_e;

endpackage

// File: rtl/mem_data_reg_load_extend.sv
// Combinational sub-word extraction: picks a byte/halfword at a byte offset and
// sign- or zero-extends it to WIDTH; word accesses pass through unshifted.
module load_extend
  import cpu_pkg::*;
#(
  parameter int WIDTH = 32,
  localparam int OFF_W = $clog2(WIDTH/8)
) (
  input  logic [WIDTH-1:0] data_i,
  input  logic [1:0]       size_i,
  input  logic             sign_ext_i,
  input  logic [OFF_W-1:0] byte_off_i,
  output logic [WIDTH-1:0] result_o
);

  logic [WIDTH-1:0] shifted;

  // Logical shift: bytes moved past the top fill with zero, so odd halfword offsets are benign.
  assign shifted = data_i >> {byte_off_i, 3'b000};

  always_comb begin
    result_o = data_i;
    case (size_i)
      SZ_BYTE: result_o = {{(WIDTH-8){sign_ext_i & shifted[7]}}, shifted[7:0]};
      SZ_HALF: result_o = {{(WIDTH-16){sign_ext_i & shifted[15]}}, shifted[15:0]};
      default: result_o = data_i;
    endcase
  end

endmodule

// File: rtl/mem_data_reg.sv
// Memory data register: loads from the CPU bus or from memory through a req/ack
// handshake with a wait-state timeout and sub-word extraction.
module mem_data_reg
  import cpu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int TIMEOUT = 15,
  localparam int OFF_W  = $clog2(WIDTH/8),
  localparam int CNT_W  = $clog2(TIMEOUT+1)
) (
  input  logic             clk,
  input  logic             clr_n,
  input  logic             enable,
  input  logic [WIDTH-1:0] BusMuxOut,
  input  logic             read,
  input  logic [1:0]       size,
  input  logic             sign_ext,
  input  logic [OFF_W-1:0] byte_off,
  input  logic [WIDTH-1:0] Mdatain,
  input  logic             mem_ack,
  output logic             mem_rd,
  output logic [WIDTH-1:0] MDRout,
  output logic             busy,
  output logic             done,
  output logic             timeout_err
);

  mdr_state_e       state_q;
  logic [WIDTH-1:0] mdr_q;
  logic [CNT_W-1:0] cnt_q;
  logic [1:0]       size_q;
  logic             sign_ext_q;
  logic [OFF_W-1:0] byte_off_q;
  logic             busy_q;
  logic             done_q;
  logic             terr_q;
  logic [WIDTH-1:0] load_d;

  // Extraction uses the fields captured when the read was accepted, not the live inputs.
  load_extend #(.WIDTH(WIDTH)) u_load_extend (
    .data_i     (Mdatain),
    .size_i     (size_q),
    .sign_ext_i (sign_ext_q),
    .byte_off_i (byte_off_q),
    .result_o   (load_d)
  );

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q    <= ST_IDLE;
      mdr_q      <= '0;
      cnt_q      <= '0;
      size_q     <= SZ_WORD;
      sign_ext_q <= 1'b0;
      byte_off_q <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      terr_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (read) begin
            state_q    <= ST_WAIT;
            busy_q     <= 1'b1;
            size_q     <= size;
            sign_ext_q <= sign_ext;
            byte_off_q <= byte_off;
            cnt_q      <= '0;
            terr_q     <= 1'b0;
          end else if (enable) begin
            mdr_q <= BusMuxOut;
          end
        end
        ST_WAIT: begin
          // An ack always wins over the timeout check on the same cycle.
          if (mem_ack) begin
            mdr_q   <= load_d;
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end else if (cnt_q == CNT_W'(TIMEOUT-1)) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            terr_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign mem_rd      = busy_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign timeout_err = terr_q;
  assign MDRout      = mdr_q;

endmodule

// File: tb/tb_mem_data_reg.sv
// Scoreboarded bench for mem_data_reg: directed reads push expected words, monitors
// pop them on each done pulse; control outputs are checked inline.
module tb_mem_data_reg;

  logic        clk;
  logic        clr_n, enable, read, sign_ext, mem_ack;
  logic [31:0] BusMuxOut, Mdatain;
  logic [1:0]  size;
  logic [1:0]  byte_off;
  logic        mem_rd, busy, done, timeout_err;
  logic [31:0] MDRout;

  logic        clr64, en64, read64, sx64, ack64;
  logic [63:0] bus64, md64;
  logic [1:0]  size64;
  logic [2:0]  off64;
  logic        mem_rd64, busy64, done64, terr64;
  logic [63:0] mdr64;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp32[$];
  logic [63:0] exp64[$];

  mem_data_reg #(.WIDTH(32), .TIMEOUT(15)) u_dut32 (
    .clk(clk), .clr_n(clr_n), .enable(enable), .BusMuxOut(BusMuxOut), .read(read),
    .size(size), .sign_ext(sign_ext), .byte_off(byte_off), .Mdatain(Mdatain),
    .mem_ack(mem_ack), .mem_rd(mem_rd), .MDRout(MDRout), .busy(busy), .done(done),
    .timeout_err(timeout_err)
  );

  mem_data_reg #(.WIDTH(64), .TIMEOUT(15)) u_dut64 (
    .clk(clk), .clr_n(clr64), .enable(en64), .BusMuxOut(bus64), .read(read64),
    .size(size64), .sign_ext(sx64), .byte_off(off64), .Mdatain(md64),
    .mem_ack(ack64), .mem_rd(mem_rd64), .MDRout(mdr64), .busy(busy64), .done(done64),
    .timeout_err(terr64)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) begin
      n_cmp++;
      if (exp32.size() == 0) begin
        n_bad++;
        $display("FAIL mon32: unexpected done, MDRout=%h, nothing expected", MDRout);
      end else begin
        logic [31:0] e;
        e = exp32.pop_front();
        if (MDRout !== e) begin
          n_bad++;
          $display("FAIL mon32: MDRout=%h expected %h", MDRout, e);
        end else
          $display("mon32: read result %h ok", MDRout);
      end
    end
  end

  always @(negedge clk) begin
    if (done64) begin
      n_cmp++;
      if (exp64.size() == 0) begin
        n_bad++;
        $display("FAIL mon64: unexpected done, MDRout=%h, nothing expected", mdr64);
      end else begin
        logic [63:0] e;
        e = exp64.pop_front();
        if (mdr64 !== e) begin
          n_bad++;
          $display("FAIL mon64: MDRout=%h expected %h", mdr64, e);
        end else
          $display("mon64: read result %h ok", mdr64);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic do_read(input logic [1:0] sz, input logic sx, input logic [1:0] off,
                         input logic [31:0] data, input int waits, input logic [31:0] exp);
    int n;
    exp32.push_back(exp);
    size = sz; sign_ext = sx; byte_off = off; Mdatain = data;
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("busy_on", 64'(busy), 64'd1);
    chk("terr_clr", 64'(timeout_err), 64'd0);
    n = 0;
    for (int i = 0; i < waits; i++) begin
      if (mem_rd) n++;
      tick();
    end
    mem_ack = 1'b1;
    if (mem_rd) n++;
    tick();
    mem_ack = 1'b0;
    chk("rd_cycles", 64'(n), 64'(waits + 1));
    chk("done_pulse", 64'(done), 64'd1);
    chk("mem_rd_off", 64'(mem_rd), 64'd0);
    tick();
    chk("done_1cyc", 64'(done), 64'd0);
    $display("read32 sz=%0d sx=%0d off=%0d data=%h -> MDRout=%h", sz, sx, off, data, MDRout);
  endtask

  task automatic rd64(input logic [1:0] sz, input logic sx, input logic [2:0] off,
                      input logic [63:0] data, input logic [63:0] exp);
    exp64.push_back(exp);
    size64 = sz; sx64 = sx; off64 = off; md64 = data;
    read64 = 1'b1;
    tick();
    read64 = 1'b0;
    ack64 = 1'b1;
    tick();
    ack64 = 1'b0;
    chk("done64", 64'(done64), 64'd1);
    tick();
    $display("read64 sz=%0d sx=%0d off=%0d -> MDRout=%h", sz, sx, off, mdr64);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    clr_n = 0; enable = 0; read = 0; sign_ext = 0; mem_ack = 0;
    BusMuxOut = '0; Mdatain = '0; size = 2'b10; byte_off = '0;
    clr64 = 0; en64 = 0; read64 = 0; sx64 = 0; ack64 = 0;
    bus64 = '0; md64 = '0; size64 = 2'b10; off64 = '0;
    tick();
    chk("rst_mdr", 64'(MDRout), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_mem_rd", 64'(mem_rd), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_terr", 64'(timeout_err), 64'd0);

    // Bus load
    clr_n = 1; clr64 = 1;
    enable = 1; BusMuxOut = 32'hDEADBEEF;
    tick();
    enable = 0;
    chk("bus_load", 64'(MDRout), 64'hDEADBEEF);
    chk("bus_busy", 64'(busy), 64'd0);
    $display("bus load -> MDRout=%h", MDRout);

    // Signed byte, zero-extended halfword, word
    do_read(2'b00, 1'b1, 2'd2, 32'h1280_3456, 3, 32'hFFFFFF80);
    do_read(2'b01, 1'b0, 2'd2, 32'h8001_7FFF, 0, 32'h0000_8001);
    do_read(2'b10, 1'b0, 2'd2, 32'h8001_7FFF, 1, 32'h8001_7FFF);

    // Timeout
    size = 2'b10; read = 1;
    tick();
    read = 0;
    n = 0;
    while (mem_rd && n < 40) begin
      n++;
      tick();
    end
    chk("to_cycles", 64'(n), 64'd15);
    chk("to_busy", 64'(busy), 64'd0);
    chk("to_terr", 64'(timeout_err), 64'd1);
    chk("to_mdr", 64'(MDRout), 64'h8001_7FFF);
    chk("to_nodone", 64'(done), 64'd0);
    $display("timeout after %0d cycles, terr=%0d", n, timeout_err);
    do_read(2'b10, 1'b1, 2'd0, 32'h0BAD_F00D, 2, 32'h0BAD_F00D);

    // read + enable together: read wins, bus ignored during WAIT
    read = 1; enable = 1; BusMuxOut = 32'hCAFE_F00D; size = 2'b10;
    tick();
    read = 0; BusMuxOut = 32'h1;
    chk("conf_busy", 64'(busy), 64'd1);
    chk("conf_mdr", 64'(MDRout), 64'h0BAD_F00D);
    read = 1;
    tick();
    tick();
    chk("wait_ign", 64'(MDRout), 64'h0BAD_F00D);
    read = 0; enable = 0;
    exp32.push_back(32'h1122_3344);
    Mdatain = 32'h1122_3344; mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("b2b_done", 64'(done), 64'd1);
    exp32.push_back(32'h0000_00F0);
    read = 1; size = 2'b00; sign_ext = 0; byte_off = 2'd0; Mdatain = 32'h55AA_00F0;
    tick();
    read = 0;
    chk("b2b_busy", 64'(busy), 64'd1);
    mem_ack = 1;
    tick();
    mem_ack = 0;
    chk("b2b_done2", 64'(done), 64'd1);
    tick();
    $display("back-to-back reads -> MDRout=%h", MDRout);

    // Reset mid-read (32-bit)
    read = 1; size = 2'b10;
    tick();
    read = 0;
    tick();
    clr_n = 0;
    tick();
    chk("mid_mdr", 64'(MDRout), 64'd0);
    chk("mid_busy", 64'(busy), 64'd0);
    chk("mid_mem_rd", 64'(mem_rd), 64'd0);
    chk("mid_done", 64'(done), 64'd0);
    clr_n = 1; mem_ack = 1; Mdatain = 32'hFFFF_FFFF;
    tick();
    tick();
    mem_ack = 0;
    chk("mid_ack_ign", 64'(MDRout), 64'd0);
    $display("reset mid-read -> MDRout=%h busy=%0d", MDRout, busy);

    // Reset mid-read and sub-word boundaries (64-bit)
    size64 = 2'b00; sx64 = 1; off64 = 3'd7; md64 = 64'hA511_2233_4455_6677;
    read64 = 1;
    tick();
    read64 = 0;
    chk("m64_busy", 64'(busy64), 64'd1);
    clr64 = 0;
    tick();
    chk("m64_rst_mdr", mdr64, 64'd0);
    chk("m64_rst_busy", 64'(busy64), 64'd0);
    chk("m64_rst_terr", 64'(terr64), 64'd0);
    clr64 = 1; ack64 = 1;
    tick();
    tick();
    ack64 = 0;
    chk("m64_ack_ign", mdr64, 64'd0);
    rd64(2'b00, 1'b1, 3'd7, 64'hA511_2233_4455_6677, 64'hFFFF_FFFF_FFFF_FFA5);
    rd64(2'b00, 1'b0, 3'd7, 64'hA511_2233_4455_6677, 64'h0000_0000_0000_00A5);
    rd64(2'b01, 1'b1, 3'd7, 64'hA511_2233_4455_6677, 64'h0000_0000_0000_00A5);
    rd64(2'b10, 1'b1, 3'd3, 64'hA511_2233_4455_6677, 64'hA511_2233_4455_6677);

    tick();
    chk("sb32_empty", 64'(exp32.size()), 64'd0);
    chk("sb64_empty", 64'(exp64.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
